dds_cfg_sched: RTL and testbench

Request scheduler placed in front of the `dds` register-programming block. It shares the single programmer between two requesters: requester 0 is the host command path and requester 1 is the hop/sweep timer. The scheduler arbitrates round-robin, latches the winner's frequency, phase and mode words, and drives the programmer's `CEN`. It then tracks the programmer's `READY` handshake, which runs on the programmer's divided clock, and reports completion or timeout back to the winning requester.

---
 rtl/dds_cfg_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_dds_cfg_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_cfg_sched.sv
// Round-robin scheduler sharing one dds register programmer between the host and the hop timer.
// Define DDS_SCHED_TIMEOUT_EN to build the READY timeout watchdog and the sticky TOERR flag.
module dds_cfg_sched #(
  parameter int unsigned TIMEOUT = 300000,
  parameter int unsigned HOLDOFF = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [15:0] f0h_i,
  input  logic [31:0] f0l_i,
  input  logic [15:0] f1h_i,
  input  logic [31:0] f1l_i,
  input  logic [13:0] ptw0_i,
  input  logic [13:0] ptw1_i,
  input  logic [2:0]  mode0_i,
  input  logic [2:0]  mode1_i,
  input  logic        ready_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic        cen_o,
  output logic [15:0] fh_o,
  output logic [31:0] fl_o,
  output logic [13:0] ptw_o,
  output logic [2:0]  mode_o,
  output logic        busy_o,
  output logic        toerr_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_WAIT_LOW = 3'd3,
    S_HOLD     = 3'd4
  } state_e;

  localparam logic [19:0] HoldLoad = 20'(HOLDOFF - 1);

  state_e      state_q, state_d;
  logic        lp_q, lp_d;
  logic [19:0] cnt_q, cnt_d;
  logic        cen_q, cen_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic [15:0] fh_q, fh_d;
  logic [31:0] fl_q, fl_d;
  logic [13:0] ptw_q, ptw_d;
  logic [2:0]  mode_q, mode_d;
  logic        rdy_meta_q, rdy_s_q, rdy_prev_q;
  logic        rdy_rise_s;
  logic        win_s;
  logic        any_req_s;

  // READY comes from the divided programmer clock: synchronize, then edge-detect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      rdy_prev_q <= 1'b0;
    end else begin
      rdy_meta_q <= ready_i;
      rdy_s_q    <= rdy_meta_q;
      rdy_prev_q <= rdy_s_q;
    end
  end

  assign rdy_rise_s = rdy_s_q & ~rdy_prev_q;
  assign any_req_s  = req0_i | req1_i;
  // On a tie the requester not served last wins; otherwise the lone requester.
  assign win_s      = (req0_i & req1_i) ? ~lp_q : req1_i;

`ifdef DDS_SCHED_TIMEOUT_EN
  localparam logic [19:0] ToLoad = 20'(TIMEOUT - 1);
  logic toerr_q, toerr_d;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    lp_d    = lp_q;
    cnt_d   = cnt_q;
    cen_d   = cen_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    fh_d    = fh_q;
    fl_d    = fl_q;
    ptw_d   = ptw_q;
    mode_d  = mode_q;
`ifdef DDS_SCHED_TIMEOUT_EN
    toerr_d = toerr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          state_d = S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if (any_req_s) begin
          fh_d        = win_s ? f1h_i : f0h_i;
          fl_d        = win_s ? f1l_i : f0l_i;
          ptw_d       = win_s ? ptw1_i : ptw0_i;
          mode_d      = win_s ? mode1_i : mode0_i;
          gnt_d[win_s] = 1'b1;
          cen_d       = 1'b1;
          lp_d        = win_s;
`ifdef DDS_SCHED_TIMEOUT_EN
          toerr_d     = 1'b0;
          cnt_d       = ToLoad;
`endif
          state_d     = S_WAIT_RDY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RDY: begin
        // A READY rise beats a simultaneous timeout.
        if (rdy_rise_s) begin
          cen_d        = 1'b0;
          done_d[lp_q] = 1'b1;
          state_d      = S_WAIT_LOW;
`ifdef DDS_SCHED_TIMEOUT_EN
        end else if (cnt_q == 20'd0) begin
          cen_d   = 1'b0;
          toerr_d = 1'b1;
          cnt_d   = HoldLoad;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 20'd1;
`else
        end else begin
          state_d = S_WAIT_RDY;
`endif
        end
      end
      S_WAIT_LOW: begin
        if (!rdy_s_q) begin
          cnt_d   = HoldLoad;
          state_d = S_HOLD;
        end else begin
          state_d = S_WAIT_LOW;
        end
      end
      S_HOLD: begin
        if (cnt_q == 20'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cen_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      lp_q    <= 1'b1;
      cnt_q   <= 20'd0;
      cen_q   <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      fh_q    <= 16'd0;
      fl_q    <= 32'd0;
      ptw_q   <= 14'd0;
      mode_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      cnt_q   <= cnt_d;
      cen_q   <= cen_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      fh_q    <= fh_d;
      fl_q    <= fl_d;
      ptw_q   <= ptw_d;
      mode_q  <= mode_d;
    end
  end

`ifdef DDS_SCHED_TIMEOUT_EN
  // Sticky timeout flag, cleared by the next grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      toerr_q <= 1'b0;
    end else begin
      toerr_q <= toerr_d;
    end
  end
  assign toerr_o = toerr_q;
`else
  assign toerr_o = 1'b0;
`endif

  assign gnt0_o  = gnt_q[0];
  assign gnt1_o  = gnt_q[1];
  assign done0_o = done_q[0];
  assign done1_o = done_q[1];
  assign cen_o   = cen_q;
  assign busy_o  = busy_q;
  assign fh_o    = fh_q;
  assign fl_o    = fl_q;
  assign ptw_o   = ptw_q;
  assign mode_o  = mode_q;

endmodule

// File: tb/tb_dds_cfg_sched.sv
// Randomized bench for dds_cfg_sched against a transaction-level round-robin reference model.
module tb_dds_cfg_sched;
  localparam int TO = 100;
  localparam int HO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic [15:0] fh_in [2];
  logic [31:0] fl_in [2];
  logic [13:0] ptw_in [2];
  logic [2:0]  mode_in [2];
  logic        ready;
  logic        gnt0, gnt1, done0, done1, cen, busy, toerr;
  logic [15:0] fh;
  logic [31:0] fl;
  logic [13:0] ptw;
  logic [2:0]  mode;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int prev_done = -1;
  int lp_m = 1;
  logic [15:0] lat_fh;
  logic [31:0] lat_fl;
  logic [13:0] lat_ptw;
  logic [2:0]  lat_mode;

  always #5 clk = ~clk;

  dds_cfg_sched #(.TIMEOUT(TO), .HOLDOFF(HO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req[0]), .req1_i(req[1]),
    .f0h_i(fh_in[0]), .f0l_i(fl_in[0]), .f1h_i(fh_in[1]), .f1l_i(fl_in[1]),
    .ptw0_i(ptw_in[0]), .ptw1_i(ptw_in[1]), .mode0_i(mode_in[0]), .mode1_i(mode_in[1]),
    .ready_i(ready),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1), .cen_o(cen),
    .fh_o(fh), .fl_o(fl), .ptw_o(ptw), .mode_o(mode), .busy_o(busy), .toerr_o(toerr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic new_words(input int k);
    fh_in[k]   = 16'($urandom);
    fl_in[k]   = $urandom;
    ptw_in[k]  = 14'($urandom);
    mode_in[k] = 3'($urandom);
  endtask

  task automatic raise(input int k);
    if (!req[k]) begin
      new_words(k);
      req[k] = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_outs", {cen, gnt0, gnt1, done0, done1, busy, toerr, fh, fl, ptw, mode}, 64'd0);
    req[0] = 1'b0;
    req[1] = 1'b0;
    ready = 1'b0;
    lp_m = 1;
    prev_done = -1;
    lat_fh = 16'd0; lat_fl = 32'd0; lat_ptw = 14'd0; lat_mode = 3'd0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Wait for the next grant, then compare it with the round-robin rule.
  task automatic wait_gnt(output int lat, output int w);
    int bad;
    logic [1:0] expv;
    bad = 0;
    w = -1;
    for (lat = 1; lat <= 300; lat++) begin
      step();
      if (gnt0 || gnt1) break;
      if (cen || done0 || done1 || fh !== lat_fh || fl !== lat_fl || ptw !== lat_ptw || mode !== lat_mode)
        bad++;
    end
    check_eq("quiet_before_gnt", bad, 0);
    if (!(gnt0 || gnt1)) begin
      check_eq("gnt_seen", 0, 1);
      return;
    end
    w = (req[0] && req[1]) ? 1 - lp_m : (req[1] ? 1 : 0);
    expv = (w == 1) ? 2'b10 : 2'b01;
    check_eq("gnt_vec", {gnt1, gnt0}, expv);
    lat_fh = fh_in[w]; lat_fl = fl_in[w]; lat_ptw = ptw_in[w]; lat_mode = mode_in[w];
    check_eq("words", {fh, fl, ptw, mode}, {lat_fh, lat_fl, lat_ptw, lat_mode});
    check_eq("gnt_cen_busy_toerr", {cen, busy, toerr}, 3'b110);
    if (prev_done >= 0) check_eq("gnt_spacing_ok", (cyc - prev_done) >= HO + 3, 1);
    lp_m = w;
    req[w] = 1'b0;
  endtask

  // Programmer model: raise READY after a delay and expect DONE three cycles later.
  task automatic finish_txn(input int w, input int rdy_delay, input bit raise_other, input bit rearm);
    int bad;
    logic [1:0] expv;
    bad = 0;
    expv = (w == 1) ? 2'b10 : 2'b01;
    if (rearm) raise(w);
    for (int i = 0; i < rdy_delay; i++) begin
      if (raise_other && i == rdy_delay / 2) raise(1 - w);
      step();
      if (gnt0 || gnt1 || done0 || done1 || !cen || toerr || !busy || fh !== lat_fh || fl !== lat_fl)
        bad++;
    end
    check_eq("wait_rdy_stable", bad, 0);
    ready = 1'b1;
    step();
    check_eq("done_early1", {done1, done0}, 2'b00);
    step();
    check_eq("done_early2", {done1, done0, cen}, 3'b001);
    step();
    check_eq("done_vec", {done1, done0}, expv);
    check_eq("cen_fall", cen, 0);
    prev_done = cyc;
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
    ready = 1'b0;
  endtask

  initial begin
    int lat, w, bad;
    rst_n = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0; ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fh_in[k] = 16'd0; fl_in[k] = 32'd0; ptw_in[k] = 14'd0; mode_in[k] = 3'd0;
    end
    apply_reset();

    // Single request with known words, REQ1 arriving while busy.
    fh_in[0] = 16'h1234; fl_in[0] = 32'h89AB_CDEF; ptw_in[0] = 14'h0155; mode_in[0] = 3'd0;
    req[0] = 1'b1;
    wait_gnt(lat, w);
    check_eq("gnt_latency", lat, 2);
    check_eq("first_winner", w, 0);
    check_eq("spec_words", {fh, fl, ptw, mode}, {16'h1234, 32'h89AB_CDEF, 14'h0155, 3'd0});
    if (w >= 0) finish_txn(w, 6, 1'b1, 1'b0);
    wait_gnt(lat, w);
    check_eq("queued_winner", w, 1);
    if (w >= 0) finish_txn(w, 4, 1'b0, 1'b0);

    // Tie from reset alternates 0,1,0,1.
    apply_reset();
    raise(0);
    raise(1);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(lat, w);
      check_eq("tie_order", w, k % 2);
      if (w >= 0) finish_txn(w, int'($urandom_range(0, 20)), 1'b0, 1'b1);
    end

    // Random request patterns and READY delays.
    for (int n = 0; n < 16; n++) begin
      if (!req[0] && !req[1]) begin
        int k;
        k = int'($urandom_range(0, 2));
        if (k != 1) raise(0);
        if (k != 0) raise(1);
      end
      wait_gnt(lat, w);
      if (w >= 0) finish_txn(w, int'($urandom_range(0, 30)), 1'($urandom), 1'($urandom));
    end

    if (!req[0] && !req[1]) raise(0);
    wait_gnt(lat, w);
`ifdef DDS_SCHED_TIMEOUT_EN
    bad = 0;
    for (int i = 1; i < TO; i++) begin
      step();
      if (!cen || toerr || done0 || done1) bad++;
    end
    check_eq("timeout_wait", bad, 0);
    step();
    check_eq("timeout_fire", {cen, toerr, done1, done0}, 4'b0100);
    for (int i = 0; i < HO / 2; i++) step();
    check_eq("toerr_sticky", toerr, 1);
    prev_done = -1;
    raise(1 - w);
    wait_gnt(lat, w);
    if (w >= 0) finish_txn(w, 3, 1'b0, 1'b0);
`else
    if (w >= 0) finish_txn(w, 2000, 1'b0, 1'b0);
    check_eq("no_timeout_toerr", toerr, 0);
`endif

    // Reset during WAIT_RDY; a later READY must not complete anything.
    if (!req[0] && !req[1]) raise(0);
    wait_gnt(lat, w);
    for (int i = 0; i < 5; i++) step();
    apply_reset();
    ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done0 || done1 || busy || cen || gnt0 || gnt1) bad++;
    end
    check_eq("post_reset_quiet", bad, 0);
    ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
